// File: rtl/ev22_regfile.sv
// EV22 operand register file: 28 GPRs, two synchronized input ports, two output-port
// registers and the working register, with two combinational read ports and one write port.
module ev22_regfile #(
    parameter int DATA_W    = 16,
    parameter int NUM_GPR   = 28,
    parameter int SEL_A_W   = 5,
    parameter int SEL_B_W   = 6,
    parameter int IN_BASE   = 28,
    parameter int OUT_BASE  = 30,
    parameter int WREG_ADDR = 34
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SEL_A_W-1:0] Sel_A,
    input  logic [SEL_B_W-1:0] Sel_B,
    output logic [DATA_W-1:0]  Data_A,
    output logic [DATA_W-1:0]  Data_B,
    input  logic               We,
    input  logic [SEL_B_W-1:0] Wr_Addr,
    input  logic [DATA_W-1:0]  Wr_Data,
    input  logic [DATA_W-1:0]  In_Port_0,
    input  logic [DATA_W-1:0]  In_Port_1,
    output logic [DATA_W-1:0]  Out_Port_0,
    output logic [DATA_W-1:0]  Out_Port_1,
    output logic               Sel_Err,
    output logic               Wr_Err
);

    localparam int GPR_IW = (NUM_GPR > 1) ? $clog2(NUM_GPR) : 1;

    typedef logic [SEL_B_W-1:0] addr_t;

    localparam addr_t IN0_ADDR  = addr_t'(IN_BASE);
    localparam addr_t IN1_ADDR  = addr_t'(IN_BASE + 1);
    localparam addr_t OUT0_ADDR = addr_t'(OUT_BASE);
    localparam addr_t OUT1_ADDR = addr_t'(OUT_BASE + 1);
    localparam addr_t WREG_A    = addr_t'(WREG_ADDR);

    logic [DATA_W-1:0] gpr [NUM_GPR];
    logic [DATA_W-1:0] out_q [2];
    logic [DATA_W-1:0] wreg_q;
    logic [DATA_W-1:0] in_meta [2];
    logic [DATA_W-1:0] in_sync [2];
    logic              wr_err_q;

    logic              wr_en;
    logic              wr_ok;
    addr_t             sel_a_ext;

    function automatic logic is_gpr(addr_t a);
        return int'(a) < NUM_GPR;
    endfunction

    function automatic logic is_in_port(addr_t a);
        return (a == IN0_ADDR) || (a == IN1_ADDR);
    endfunction

    function automatic logic is_storable(addr_t a);
        return is_gpr(a) || (a == OUT0_ADDR) || (a == OUT1_ADDR) || (a == WREG_A);
    endfunction

    function automatic logic is_mapped(addr_t a);
        return is_storable(a) || is_in_port(a);
    endfunction

    function automatic logic [DATA_W-1:0] stored_val(addr_t a);
        logic [DATA_W-1:0] v;
        v = '0;
        if (is_gpr(a))           v = gpr[a[GPR_IW-1:0]];
        else if (a == IN0_ADDR)  v = in_sync[0];
        else if (a == IN1_ADDR)  v = in_sync[1];
        else if (a == OUT0_ADDR) v = out_q[0];
        else if (a == OUT1_ADDR) v = out_q[1];
        else if (a == WREG_A)    v = wreg_q;
        return v;
    endfunction

    // Reset masks the write strobe so a reset edge never stores or bypasses.
    assign wr_en     = We & rst_n;
    assign wr_ok     = wr_en & is_storable(Wr_Addr);
    assign sel_a_ext = addr_t'(Sel_A);

    always_comb begin
        Data_A = '0;
        if (is_mapped(sel_a_ext)) begin
            if (wr_ok && (Wr_Addr == sel_a_ext)) Data_A = Wr_Data;
            else                                 Data_A = stored_val(sel_a_ext);
        end
    end

    always_comb begin
        Data_B = '0;
        if (is_mapped(Sel_B)) begin
            if (wr_ok && (Wr_Addr == Sel_B)) Data_B = Wr_Data;
            else                             Data_B = stored_val(Sel_B);
        end
    end

    assign Sel_Err = !is_mapped(sel_a_ext) || !is_mapped(Sel_B);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_GPR; i++) gpr[i] <= '0;
            for (int p = 0; p < 2; p++) begin
                out_q[p]   <= '0;
                in_meta[p] <= '0;
                in_sync[p] <= '0;
            end
            wreg_q   <= '0;
            wr_err_q <= 1'b0;
        end else begin
            in_meta[0] <= In_Port_0;
            in_meta[1] <= In_Port_1;
            in_sync[0] <= in_meta[0];
            in_sync[1] <= in_meta[1];
            wr_err_q   <= We && !is_storable(Wr_Addr);
            if (wr_ok) begin
                if (is_gpr(Wr_Addr))            gpr[Wr_Addr[GPR_IW-1:0]] <= Wr_Data;
                else if (Wr_Addr == OUT0_ADDR)  out_q[0] <= Wr_Data;
                else if (Wr_Addr == OUT1_ADDR)  out_q[1] <= Wr_Data;
                else if (Wr_Addr == WREG_A)     wreg_q   <= Wr_Data;
            end
        end
    end

    assign Out_Port_0 = out_q[0];
    assign Out_Port_1 = out_q[1];
    assign Wr_Err     = wr_err_q;

endmodule
